// File: rtl/led_pattern_pkg.sv
// LED pattern generator shared types: mode encodings and pattern helpers.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROTL   = 2'b00,
        MODE_ROTR   = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_FILL   = 2'b11
    } mode_e;

    function automatic logic [31:0] init_pattern(input mode_e m);
        return (m == MODE_FILL) ? 32'd0 : 32'd1;
    endfunction

    // Thermometer mask with the low k bits set, i.e. (2^k)-1.
    function automatic logic [31:0] fill_mask(input logic [5:0] k);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (6'(i) < k);
        end
        return m;
    endfunction

endpackage

// File: rtl/led_pattern_if.sv
// Control/status bundle between a pattern consumer and the generator.
interface led_pattern_if #(
    parameter int LED_W = 8
);
    logic             Run;
    logic [1:0]       Mode;
    logic [1:0]       Speed;
    logic [LED_W-1:0] LED;
    logic             Step;

    modport master (output Run, Mode, Speed, input LED, Step);
    modport slave  (input Run, Mode, Speed, output LED, Step);
endinterface

// File: rtl/led_pattern_gen_timer.sv
// Clock-enable step timer: strobes once every STEP_CYCLES >> speed cycles.
module step_timer #(
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] speed,
    input  logic       clear,
    output logic       strobe
);
    localparam int TW = $clog2(STEP_CYCLES);

    logic [TW-1:0] r_count;
    logic [31:0]   w_period;
    logic [31:0]   w_count;

    assign w_period = 32'(STEP_CYCLES) >> speed;
    assign w_count  = 32'(r_count);
    // >= rather than == so a faster speed past the new limit fires at once.
    assign strobe   = run && (w_count >= (w_period - 32'd1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
        end else if (strobe) begin
            r_count <= '0;
        end else if (run) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate, bounce and fill patterns on a step timer.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int LED_W       = 8,
    parameter int STEP_CYCLES = 25_000_000
) (
    input  logic          CLK_50MHz,
    input  logic          Reset,
    led_pattern_if.slave  bus
);
    localparam int KW = $clog2(LED_W + 1);

    logic [LED_W-1:0] r_led;
    logic [LED_W-1:0] w_led_nxt;
    logic             r_step;
    logic             r_dir_up;
    logic             w_dir_nxt;
    logic [KW-1:0]    r_k;
    logic [KW-1:0]    w_k_nxt;
    mode_e            r_prev_mode;
    mode_e            w_mode;
    logic             w_strobe;
    logic             w_mode_chg;
    logic             w_take;
    logic             w_onehot;
    logic             w_up;

    assign w_mode     = mode_e'(bus.Mode);
    // A change seen while frozen stays pending until Run returns.
    assign w_mode_chg = bus.Run && (w_mode != r_prev_mode);
    assign w_take     = w_strobe && !w_mode_chg;

    step_timer #(
        .STEP_CYCLES (STEP_CYCLES)
    ) u_timer (
        .clk    (CLK_50MHz),
        .rst    (Reset),
        .run    (bus.Run),
        .speed  (bus.Speed),
        .clear  (w_mode_chg),
        .strobe (w_strobe)
    );

    assign w_onehot = (r_led != '0) && ((r_led & (r_led - 1'b1)) == '0);
    assign w_up     = r_dir_up ? !r_led[LED_W-1] : r_led[0];

    always_comb begin
        w_led_nxt = r_led;
        w_dir_nxt = r_dir_up;
        w_k_nxt   = r_k;
        unique case (w_mode)
            MODE_ROTL: begin
                w_led_nxt = w_onehot ? {r_led[LED_W-2:0], r_led[LED_W-1]}
                                     : LED_W'(1);
            end
            MODE_ROTR: begin
                w_led_nxt = w_onehot ? {r_led[0], r_led[LED_W-1:1]}
                                     : LED_W'(1);
            end
            MODE_BOUNCE: begin
                if (!w_onehot) begin
                    w_led_nxt = LED_W'(1);
                    w_dir_nxt = 1'b1;
                end else begin
                    w_led_nxt = w_up ? (r_led << 1) : (r_led >> 1);
                    w_dir_nxt = w_up ? !w_led_nxt[LED_W-1] : w_led_nxt[0];
                end
            end
            MODE_FILL: begin
                w_k_nxt   = (r_k == KW'(LED_W)) ? '0 : r_k + 1'b1;
                w_led_nxt = LED_W'(fill_mask(6'(w_k_nxt)));
            end
        endcase
    end

    always_ff @(posedge CLK_50MHz) begin
        if (Reset) begin
            r_led       <= LED_W'(1);
            r_step      <= 1'b0;
            r_dir_up    <= 1'b1;
            r_k         <= '0;
            r_prev_mode <= w_mode;
        end else begin
            r_step <= w_take;
            if (w_mode_chg) begin
                r_led       <= LED_W'(init_pattern(w_mode));
                r_dir_up    <= 1'b1;
                r_k         <= '0;
                r_prev_mode <= w_mode;
            end else if (w_take) begin
                r_led    <= w_led_nxt;
                r_dir_up <= w_dir_nxt;
                r_k      <= w_k_nxt;
            end
        end
    end

    assign bus.LED  = r_led;
    assign bus.Step = r_step;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen with LED_W=8, STEP_CYCLES=8.
module tb_led_pattern_gen;

    logic CLK_50MHz = 1'b0;
    logic Reset     = 1'b1;
    int   n_vec     = 0;
    int   n_err     = 0;

    logic [7:0] bounce_tab [14] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                    8'h40, 8'h80, 8'h40, 8'h20, 8'h10,
                                    8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] fill_tab [9]    = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F,
                                    8'h3F, 8'h7F, 8'hFF, 8'h00};
    logic [7:0] rotl_tab [8]    = '{8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h01};

    led_pattern_if #(.LED_W(8)) ifc ();

    led_pattern_gen #(
        .LED_W       (8),
        .STEP_CYCLES (8)
    ) dut (
        .CLK_50MHz (CLK_50MHz),
        .Reset     (Reset),
        .bus       (ifc)
    );

    always #5 CLK_50MHz = ~CLK_50MHz;

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK_50MHz);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Seven quiet cycles, then the step edge with the expected LED.
    task automatic one_step(input string tag, input logic [7:0] exp);
        tick_n(7);
        chk({tag, "_gap"}, {31'd0, ifc.Step}, 32'd0);
        tick_n(1);
        chk({tag, "_led"}, {24'd0, ifc.LED}, {24'd0, exp});
        chk({tag, "_stp"}, {31'd0, ifc.Step}, 32'd1);
    endtask

    initial begin
        ifc.Run   = 1'b1;
        ifc.Mode  = 2'b00;
        ifc.Speed = 2'b00;
        tick_n(3);
        chk("rst_led", {24'd0, ifc.LED}, 32'h01);
        chk("rst_stp", {31'd0, ifc.Step}, 32'd0);

        Reset = 1'b0;
        tick_n(7);
        chk("pre_led", {24'd0, ifc.LED}, 32'h01);
        chk("pre_stp", {31'd0, ifc.Step}, 32'd0);
        tick_n(1);
        chk("first_led", {24'd0, ifc.LED}, 32'h02);
        chk("first_stp", {31'd0, ifc.Step}, 32'd1);
        for (int i = 1; i < 8; i++) one_step("rotl", rotl_tab[i]);

        ifc.Mode = 2'b10;
        tick_n(1);
        chk("bnc_load", {24'd0, ifc.LED}, 32'h01);
        chk("bnc_lstp", {31'd0, ifc.Step}, 32'd0);
        for (int i = 0; i < 14; i++) one_step("bounce", bounce_tab[i]);

        ifc.Mode = 2'b11;
        tick_n(1);
        chk("fill_load", {24'd0, ifc.LED}, 32'h00);
        for (int i = 0; i < 9; i++) one_step("fill", fill_tab[i]);

        ifc.Mode = 2'b00;
        tick_n(1);
        chk("spd_load", {24'd0, ifc.LED}, 32'h01);
        tick_n(5);
        ifc.Speed = 2'b11;
        tick_n(1);
        chk("spd3_a", {24'd0, ifc.LED}, 32'h02);
        chk("spd3_as", {31'd0, ifc.Step}, 32'd1);
        tick_n(1);
        chk("spd3_b", {24'd0, ifc.LED}, 32'h04);
        chk("spd3_bs", {31'd0, ifc.Step}, 32'd1);
        tick_n(1);
        chk("spd3_c", {24'd0, ifc.LED}, 32'h08);
        ifc.Speed = 2'b10;
        tick_n(1);
        chk("spd2_gap", {31'd0, ifc.Step}, 32'd0);
        tick_n(1);
        chk("spd2_a", {24'd0, ifc.LED}, 32'h10);
        chk("spd2_as", {31'd0, ifc.Step}, 32'd1);
        tick_n(1);
        chk("spd2_gap2", {31'd0, ifc.Step}, 32'd0);
        tick_n(1);
        chk("spd2_b", {24'd0, ifc.LED}, 32'h20);
        ifc.Speed = 2'b00;

        tick_n(7);
        chk("coll_pre", {24'd0, ifc.LED}, 32'h20);
        ifc.Mode = 2'b01;
        tick_n(1);
        chk("coll_led", {24'd0, ifc.LED}, 32'h01);
        chk("coll_stp", {31'd0, ifc.Step}, 32'd0);
        one_step("coll_next", 8'h80);

        tick_n(3);
        ifc.Run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick_n(1);
            chk("frz_led", {24'd0, ifc.LED}, 32'h80);
            chk("frz_stp", {31'd0, ifc.Step}, 32'd0);
        end
        ifc.Run = 1'b1;
        tick_n(4);
        chk("resume_gap", {31'd0, ifc.Step}, 32'd0);
        tick_n(1);
        chk("resume_led", {24'd0, ifc.LED}, 32'h40);
        chk("resume_stp", {31'd0, ifc.Step}, 32'd1);

        ifc.Run = 1'b0;
        tick_n(2);
        Reset = 1'b1;
        tick_n(1);
        chk("rst_frz_led", {24'd0, ifc.LED}, 32'h01);
        chk("rst_frz_stp", {31'd0, ifc.Step}, 32'd0);
        Reset   = 1'b0;
        ifc.Run = 1'b1;
        one_step("post_rst", 8'h80);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
